// File: rtl/hazard_ctrl_mc.sv
// Hazard controller for the 5-stage RV32 pipeline: operand forwarding, multi-cycle
// load-use stall, branch flush and a scoreboard for one multi-cycle MUL/DIV unit.
module hazard_ctrl_mc #(
    parameter int REG_ADDR_W = 5,
    parameter int LOAD_LAT   = 1,
    parameter int MD_LAT     = 4,
    parameter int MD_CNT_W   = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RegWrite_M,
    input  logic                  RegWrite_W,
    input  logic [REG_ADDR_W-1:0] Rd_E,
    input  logic [REG_ADDR_W-1:0] Rd_M,
    input  logic [REG_ADDR_W-1:0] Rd_W,
    input  logic [REG_ADDR_W-1:0] RS1_D,
    input  logic [REG_ADDR_W-1:0] RS2_D,
    input  logic [REG_ADDR_W-1:0] Rd_D,
    input  logic [REG_ADDR_W-1:0] RS1_E,
    input  logic [REG_ADDR_W-1:0] RS2_E,
    input  logic [1:0]            ResultSrc_E,
    input  logic                  MdOp_D,
    input  logic                  MdStart_E,
    input  logic                  PCSrc_E,
    output logic [1:0]            ForwardAE,
    output logic [1:0]            ForwardBE,
    output logic                  StallF,
    output logic                  StallD,
    output logic                  FlushD,
    output logic                  FlushE,
    output logic                  MdBusy,
    output logic                  MdDone,
    output logic [REG_ADDR_W-1:0] MdRd
);

    localparam int NUM_REGS = 2 ** REG_ADDR_W;
    localparam logic [2:0] LOAD_RELOAD = 3'(LOAD_LAT - 1);
    localparam logic [MD_CNT_W-1:0] MD_RELOAD = MD_CNT_W'(MD_LAT - 1);

    logic [2:0]            loadCnt;
    logic [MD_CNT_W-1:0]   mdCnt;
    logic                  mdBusyQ;
    logic [REG_ADDR_W-1:0] mdRdQ;
    logic [NUM_REGS-1:0]   pending;

    logic loadHazard;
    logic loadDetect;
    logic loadStall;
    logic mdIssue;
    logic mdDone;
    logic mdStall;
    logic stall;

    // M stage wins over W; register x0 is never forwarded.
    function automatic logic [1:0] forwardSel(
        input logic [REG_ADDR_W-1:0] rs,
        input logic                  wrM,
        input logic [REG_ADDR_W-1:0] rdM,
        input logic                  wrW,
        input logic [REG_ADDR_W-1:0] rdW
    );
        if (wrM && (rdM != '0) && (rdM == rs))
            return 2'b10;
        else if (wrW && (rdW != '0) && (rdW == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    always_comb begin
        loadHazard = (ResultSrc_E == 2'b01) && (Rd_E != '0) &&
                     ((Rd_E == RS1_D) || (Rd_E == RS2_D));
        loadDetect = (loadCnt == '0) && loadHazard;
        loadStall  = loadDetect || (loadCnt != '0);

        mdIssue = MdStart_E && !mdBusyQ;
        mdDone  = mdBusyQ && (mdCnt == '0);
        // The done cycle still stalls on register matches: the write lands at its edge.
        mdStall = ((RS1_D != '0) && pending[RS1_D]) ||
                  ((RS2_D != '0) && pending[RS2_D]) ||
                  ((Rd_D  != '0) && pending[Rd_D])  ||
                  (MdOp_D && mdBusyQ && !mdDone);

        stall = loadStall || mdStall;
    end

    // A taken branch squashes the dependent instruction, so the remaining bubble is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            loadCnt <= '0;
        else if (PCSrc_E)
            loadCnt <= '0;
        else if (loadCnt != '0)
            loadCnt <= loadCnt - 3'd1;
        else if (loadDetect)
            loadCnt <= LOAD_RELOAD;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mdBusyQ <= 1'b0;
            mdCnt   <= '0;
            mdRdQ   <= '0;
            pending <= '0;
        end else if (mdIssue) begin
            mdBusyQ <= 1'b1;
            mdCnt   <= MD_RELOAD;
            mdRdQ   <= Rd_E;
            if (Rd_E != '0)
                pending[Rd_E] <= 1'b1;
        end else if (mdBusyQ) begin
            if (mdDone) begin
                mdBusyQ        <= 1'b0;
                pending[mdRdQ] <= 1'b0;
            end else begin
                mdCnt <= mdCnt - 1'b1;
            end
        end
    end

    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        StallF    = 1'b0;
        StallD    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        MdBusy    = 1'b0;
        MdDone    = 1'b0;
        MdRd      = '0;
        if (rst) begin
            ForwardAE = forwardSel(RS1_E, RegWrite_M, Rd_M, RegWrite_W, Rd_W);
            ForwardBE = forwardSel(RS2_E, RegWrite_M, Rd_M, RegWrite_W, Rd_W);
            StallF    = stall && !PCSrc_E;
            StallD    = stall && !PCSrc_E;
            FlushD    = PCSrc_E;
            FlushE    = stall || PCSrc_E;
            MdBusy    = mdBusyQ;
            MdDone    = mdDone;
            MdRd      = mdRdQ;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Bench for hazard_ctrl_mc: two instances (LOAD_LAT 1/MD_LAT 4 and LOAD_LAT 3/MD_LAT 6)
// on shared inputs, compared every cycle against a cycle-count reference model.
module tb_hazard_ctrl_mc;

    logic       clk;
    logic       rst;
    logic       RegWrite_M, RegWrite_W;
    logic [4:0] Rd_E, Rd_M, Rd_W, RS1_D, RS2_D, Rd_D, RS1_E, RS2_E;
    logic [1:0] ResultSrc_E;
    logic       MdOp_D, MdStart_E, PCSrc_E;

    logic [1:0] fwdA [2];
    logic [1:0] fwdB [2];
    logic       stallF [2];
    logic       stallD [2];
    logic       flushD [2];
    logic       flushE [2];
    logic       mdBusy [2];
    logic       mdDone [2];
    logic [4:0] mdRd [2];

    int passCount  = 0;
    int checkCount = 0;

    // Reference model: remaining stall/busy cycles and the set of pending registers.
    int         loadLat [2] = '{1, 3};
    int         mdLat   [2] = '{4, 6};
    int         ldLeft  [2];
    int         mdLeft  [2];
    logic [4:0] mdDest  [2];
    bit  [31:0] pend    [2];

    hazard_ctrl_mc #(.REG_ADDR_W(5), .LOAD_LAT(1), .MD_LAT(4), .MD_CNT_W(6)) dut (
        .clk(clk), .rst(rst),
        .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W),
        .Rd_E(Rd_E), .Rd_M(Rd_M), .Rd_W(Rd_W),
        .RS1_D(RS1_D), .RS2_D(RS2_D), .Rd_D(Rd_D),
        .RS1_E(RS1_E), .RS2_E(RS2_E),
        .ResultSrc_E(ResultSrc_E), .MdOp_D(MdOp_D), .MdStart_E(MdStart_E), .PCSrc_E(PCSrc_E),
        .ForwardAE(fwdA[0]), .ForwardBE(fwdB[0]),
        .StallF(stallF[0]), .StallD(stallD[0]), .FlushD(flushD[0]), .FlushE(flushE[0]),
        .MdBusy(mdBusy[0]), .MdDone(mdDone[0]), .MdRd(mdRd[0])
    );

    hazard_ctrl_mc #(.REG_ADDR_W(5), .LOAD_LAT(3), .MD_LAT(6), .MD_CNT_W(6)) dut3 (
        .clk(clk), .rst(rst),
        .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W),
        .Rd_E(Rd_E), .Rd_M(Rd_M), .Rd_W(Rd_W),
        .RS1_D(RS1_D), .RS2_D(RS2_D), .Rd_D(Rd_D),
        .RS1_E(RS1_E), .RS2_E(RS2_E),
        .ResultSrc_E(ResultSrc_E), .MdOp_D(MdOp_D), .MdStart_E(MdStart_E), .PCSrc_E(PCSrc_E),
        .ForwardAE(fwdA[1]), .ForwardBE(fwdB[1]),
        .StallF(stallF[1]), .StallD(stallD[1]), .FlushD(flushD[1]), .FlushE(flushE[1]),
        .MdBusy(mdBusy[1]), .MdDone(mdDone[1]), .MdRd(mdRd[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    endtask

    function automatic logic [1:0] refForward(input logic [4:0] rs);
        if (RegWrite_M && Rd_M != 0 && Rd_M == rs) return 2'b10;
        if (RegWrite_W && Rd_W != 0 && Rd_W == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic loadHazardRef();
        return (ResultSrc_E == 2'b01) && (Rd_E != 0) && (Rd_E == RS1_D || Rd_E == RS2_D);
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 2; i++) begin
            ldLeft[i] = 0;
            mdLeft[i] = 0;
            mdDest[i] = '0;
            pend[i]   = '0;
        end
    endtask

    // Compares every output of both instances against the model's view of this cycle.
    task automatic checkAll(input string tag);
        for (int i = 0; i < 2; i++) begin
            logic       busy, done, stall, live;
            logic [1:0] expA, expB;
            busy  = mdLeft[i] > 0;
            done  = mdLeft[i] == 1;
            stall = (ldLeft[i] > 0) || loadHazardRef() ||
                    (RS1_D != 0 && pend[i][RS1_D]) ||
                    (RS2_D != 0 && pend[i][RS2_D]) ||
                    (Rd_D  != 0 && pend[i][Rd_D])  ||
                    (MdOp_D && busy && !done);
            live = rst;
            expA = live ? refForward(RS1_E) : 2'b00;
            expB = live ? refForward(RS2_E) : 2'b00;
            checkOutput($sformatf("%s/u%0d/ForwardAE", tag, i), 32'(fwdA[i]), 32'(expA));
            checkOutput($sformatf("%s/u%0d/ForwardBE", tag, i), 32'(fwdB[i]), 32'(expB));
            checkOutput($sformatf("%s/u%0d/StallF", tag, i), 32'(stallF[i]), 32'(live && stall && !PCSrc_E));
            checkOutput($sformatf("%s/u%0d/StallD", tag, i), 32'(stallD[i]), 32'(live && stall && !PCSrc_E));
            checkOutput($sformatf("%s/u%0d/FlushD", tag, i), 32'(flushD[i]), 32'(live && PCSrc_E));
            checkOutput($sformatf("%s/u%0d/FlushE", tag, i), 32'(flushE[i]), 32'(live && (stall || PCSrc_E)));
            checkOutput($sformatf("%s/u%0d/MdBusy", tag, i), 32'(mdBusy[i]), 32'(live && busy));
            checkOutput($sformatf("%s/u%0d/MdDone", tag, i), 32'(mdDone[i]), 32'(live && done));
            checkOutput($sformatf("%s/u%0d/MdRd", tag, i), 32'(mdRd[i]), live ? 32'(mdDest[i]) : 32'd0);
        end
    endtask

    // Applies the effect of the coming clock edge to the model.
    task automatic advance();
        if (!rst) begin
            modelReset();
            return;
        end
        for (int i = 0; i < 2; i++) begin
            if (PCSrc_E)
                ldLeft[i] = 0;
            else if (ldLeft[i] > 0)
                ldLeft[i] = ldLeft[i] - 1;
            else if (loadHazardRef())
                ldLeft[i] = loadLat[i] - 1;

            if (mdLeft[i] > 0) begin
                mdLeft[i] = mdLeft[i] - 1;
                if (mdLeft[i] == 0)
                    pend[i][mdDest[i]] = 1'b0;
            end else if (MdStart_E) begin
                mdLeft[i] = mdLat[i];
                mdDest[i] = Rd_E;
                if (Rd_E != 0)
                    pend[i][Rd_E] = 1'b1;
            end
        end
    endtask

    task automatic clearInputs();
        RegWrite_M = 0; RegWrite_W = 0;
        Rd_E = 0; Rd_M = 0; Rd_W = 0;
        RS1_D = 0; RS2_D = 0; Rd_D = 0; RS1_E = 0; RS2_E = 0;
        ResultSrc_E = 0; MdOp_D = 0; MdStart_E = 0; PCSrc_E = 0;
    endtask

    task automatic applyStimulus();
        RegWrite_M  = 1'($urandom_range(0, 1));
        RegWrite_W  = 1'($urandom_range(0, 1));
        Rd_E        = 5'($urandom_range(0, 7));
        Rd_M        = 5'($urandom_range(0, 7));
        Rd_W        = 5'($urandom_range(0, 7));
        RS1_D       = 5'($urandom_range(0, 7));
        RS2_D       = 5'($urandom_range(0, 7));
        Rd_D        = 5'($urandom_range(0, 7));
        RS1_E       = 5'($urandom_range(0, 7));
        RS2_E       = 5'($urandom_range(0, 7));
        ResultSrc_E = 2'($urandom_range(0, 3));
        MdOp_D      = ($urandom_range(0, 3) == 0);
        MdStart_E   = ($urandom_range(0, 5) == 0);
        PCSrc_E     = ($urandom_range(0, 7) == 0);
    endtask

    task automatic settle(input string tag);
        #1;
        checkAll(tag);
    endtask

    task automatic finishCycle();
        advance();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        clearInputs();
        modelReset();
        #2;
        checkAll("reset");
        checkOutput("resetMdBusy", 32'(mdBusy[0]), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Forwarding priority
        RegWrite_M = 1; RegWrite_W = 1; Rd_M = 5; Rd_W = 5; RS1_E = 5;
        settle("fwdM");
        checkOutput("fwdPrioM", 32'(fwdA[0]), 32'd2);
        finishCycle();
        Rd_M = 0;
        settle("fwdW");
        checkOutput("fwdPrioW", 32'(fwdA[0]), 32'd1);
        finishCycle();
        Rd_W = 0;
        settle("fwdNone");
        checkOutput("fwdNone", 32'(fwdA[0]), 32'd0);
        finishCycle();
        clearInputs();

        // Load-use: one bubble on u0, three on u1
        ResultSrc_E = 2'b01; Rd_E = 7; RS2_D = 7;
        settle("ld0");
        checkOutput("ld0/u0StallF", 32'(stallF[0]), 32'd1);
        checkOutput("ld0/u1FlushE", 32'(flushE[1]), 32'd1);
        finishCycle();
        ResultSrc_E = 2'b00; Rd_E = 0;
        for (int k = 1; k <= 3; k++) begin
            settle($sformatf("ld%0d", k));
            checkOutput($sformatf("ld%0d/u0StallF", k), 32'(stallF[0]), 32'd0);
            checkOutput($sformatf("ld%0d/u1StallF", k), 32'(stallF[1]), 32'(k < 3));
            finishCycle();
        end
        ResultSrc_E = 2'b01; Rd_E = 0; RS2_D = 0;
        settle("ldX0");
        checkOutput("ldX0/u1StallF", 32'(stallF[1]), 32'd0);
        finishCycle();
        clearInputs();

        // MUL/DIV issue to x9 and dependent read
        MdStart_E = 1; Rd_E = 9;
        settle("mdIssue");
        finishCycle();
        MdStart_E = 0; Rd_E = 0; RS1_D = 9;
        for (int k = 1; k <= 5; k++) begin
            settle($sformatf("md%0d", k));
            checkOutput($sformatf("md%0d/u0Busy", k), 32'(mdBusy[0]), 32'(k <= 4));
            checkOutput($sformatf("md%0d/u0Done", k), 32'(mdDone[0]), 32'(k == 4));
            checkOutput($sformatf("md%0d/u0StallF", k), 32'(stallF[0]), 32'(k <= 4));
            if (k <= 4) checkOutput($sformatf("md%0d/u0MdRd", k), 32'(mdRd[0]), 32'd9);
            finishCycle();
        end
        clearInputs();
        repeat (2) begin settle("mdDrain"); finishCycle(); end

        // WAW, independent source, MdOp while busy, ignored second start
        MdStart_E = 1; Rd_E = 9;
        settle("wawIssue");
        finishCycle();
        MdStart_E = 0; Rd_E = 0; Rd_D = 9; RS1_D = 3;
        settle("waw");
        checkOutput("waw/u0StallF", 32'(stallF[0]), 32'd1);
        finishCycle();
        Rd_D = 0;
        settle("indep");
        checkOutput("indep/u0StallF", 32'(stallF[0]), 32'd0);
        finishCycle();
        MdOp_D = 1; MdStart_E = 1; Rd_E = 4;
        settle("mdOpBusy");
        checkOutput("mdOpBusy/u0StallF", 32'(stallF[0]), 32'd1);
        finishCycle();
        MdStart_E = 0; Rd_E = 0;
        settle("mdOpDone");
        checkOutput("mdOpDone/u0Done", 32'(mdDone[0]), 32'd1);
        checkOutput("mdOpDone/u0StallF", 32'(stallF[0]), 32'd0);
        checkOutput("ignoredStart/u0MdRd", 32'(mdRd[0]), 32'd9);
        finishCycle();
        MdOp_D = 0; RS1_D = 4;
        settle("noPend4");
        checkOutput("noPend4/u0StallF", 32'(stallF[0]), 32'd0);
        finishCycle();
        clearInputs();
        repeat (3) begin settle("wawDrain"); finishCycle(); end

        // Branch in the first cycle of a three-cycle load stall
        ResultSrc_E = 2'b01; Rd_E = 7; RS1_D = 7; PCSrc_E = 1;
        settle("brLd");
        checkOutput("brLd/u1FlushD", 32'(flushD[1]), 32'd1);
        checkOutput("brLd/u1FlushE", 32'(flushE[1]), 32'd1);
        checkOutput("brLd/u1StallF", 32'(stallF[1]), 32'd0);
        finishCycle();
        ResultSrc_E = 2'b00; Rd_E = 0; PCSrc_E = 0;
        settle("brAfter");
        checkOutput("brAfter/u1StallF", 32'(stallF[1]), 32'd0);
        finishCycle();
        clearInputs();

        // Asynchronous reset in the middle of a MUL/DIV
        MdStart_E = 1; Rd_E = 9;
        settle("rstIssue");
        finishCycle();
        MdStart_E = 0; Rd_E = 0; RS1_D = 9; RegWrite_M = 1; Rd_M = 5; RS1_E = 5;
        settle("rstBusy1");
        finishCycle();
        settle("rstBusy2");
        #2;
        rst = 1'b0;
        #1;
        modelReset();
        checkAll("asyncRst");
        checkOutput("asyncRst/u0MdBusy", 32'(mdBusy[0]), 32'd0);
        checkOutput("asyncRst/u0ForwardAE", 32'(fwdA[0]), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        RegWrite_M = 0;
        settle("postRst");
        checkOutput("postRst/u0StallF", 32'(stallF[0]), 32'd0);
        finishCycle();
        clearInputs();

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            applyStimulus();
            settle("rand");
            finishCycle();
        end

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl_mc.md
Name: hazard_ctrl_mc

Overview:
Parametrised next-generation hazard controller for the 5-stage RV32 pipeline. It provides M/W-to-E operand forwarding, a load-use stall whose length is configurable for slower data memories, and branch flush. It adds a scoreboard and a latency counter for a single multi-cycle MUL/DIV unit that writes the register file directly on completion. It sits beside the pipeline registers and drives their stall/flush enables.

Parameters:
REG_ADDR_W, 5, register address width (pending-bit vector is 2**REG_ADDR_W wide)
LOAD_LAT, 1, load-use stall length in cycles (legal 1..7)
MD_LAT, 4, MUL/DIV latency in cycles from issue to write-back (legal 2..63)
MD_CNT_W, 6, MUL/DIV countdown counter width (must hold MD_LAT-1)

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  asynchronous, active-low reset
RegWrite_M, RegWrite_W  in  1  register write enables of the M and W stages
Rd_E, Rd_M, Rd_W  in  REG_ADDR_W  destination registers of the E, M and W stages
RS1_D, RS2_D, Rd_D  in  REG_ADDR_W  sources and destination of the instruction in D
RS1_E, RS2_E  in  REG_ADDR_W  sources of the instruction in E
ResultSrc_E  in  2  2'b01 = the instruction in E is a load
MdOp_D  in  1  the instruction in D is a MUL/DIV
MdStart_E  in  1  a MUL/DIV is issuing from E this cycle
PCSrc_E  in  1  branch/jump taken in E
ForwardAE, ForwardBE  out  2  2'b10 = from M, 2'b01 = from W, 2'b00 = from register file
StallF, StallD, FlushD, FlushE  out  1  pipeline controls
MdBusy  out  1  MUL/DIV in flight
MdDone  out  1  one-cycle write-back strobe
MdRd  out  REG_ADDR_W  destination register of the MUL/DIV in flight

Behaviour:
- Reset (rst=0, asynchronous): load counter=0, MD counter=0, MdBusy=0, pending vector=0, MdRd=0. While rst=0, all combinational outputs are forced to 0.
- Forwarding, per operand (combinational):
  - M match (RegWrite_M, Rd_M≠0, Rd_M==RS_E) gives 2'b10.
  - Otherwise W match gives 2'b01.
  - Otherwise 2'b00. M has priority over W.
- Load-use detect: load counter==0, ResultSrc_E==01, Rd_E≠0, and Rd_E matches RS1_D or RS2_D.
  - On detect, loadStall=1 and the counter loads LOAD_LAT-1.
  - While counter>0: loadStall=1 and the counter decrements each cycle.
  - Total stall = exactly LOAD_LAT cycles. LOAD_LAT=1 gives the classic single bubble.
- MUL/DIV scoreboard:
  - Issue: MdStart_E & ~MdBusy. At that edge: MdBusy←1, counter←MD_LAT-1, MdRd←Rd_E, pending[Rd_E]←1 (only if Rd_E≠0).
  - While busy, the counter decrements each cycle.
  - MdDone=1 combinationally in the cycle where MdBusy=1 and counter==0. That cycle's edge clears MdBusy and pending[MdRd]. The MD unit writes the register file at that same edge.
  - MdBusy is high for exactly MD_LAT cycles.
  - MdStart_E while MdBusy=1 is ignored: no state change.
- mdStall (combinational) = any of:
  - pending[RS1_D] with RS1_D≠0.
  - pending[RS2_D] with RS2_D≠0.
  - pending[Rd_D] with Rd_D≠0 (WAW).
  - MdOp_D & MdBusy & ~MdDone.
  - The MdDone cycle still stalls on register matches. Release happens the next cycle, when the register file holds the result.
- MUL/DIV instructions carry RegWrite=0 through M/W. The forwarding paths never supply MD results.
- Combine: stall = loadStall | mdStall.
  - StallF = StallD = stall & ~PCSrc_E.
  - FlushD = PCSrc_E.
  - FlushE = stall | PCSrc_E.
- PCSrc_E with a load stall: at the edge the load counter is cleared to 0, because the dependent instruction in D is squashed.
- PCSrc_E with MdBusy: scoreboard unaffected, because the in-flight MD op is older than the branch.
- Reset mid-operation discards the in-flight MD op and all pending bits.

Test Plan:
- Forwarding priority: RegWrite_M=RegWrite_W=1, Rd_M=Rd_W=RS1_E=5 → ForwardAE=10. Set Rd_M=0 → ForwardAE=01. Rd=0 on both → 00.
- Load-use, LOAD_LAT=1 then 3: lw x7 in E, RS2_D=7 → StallF/StallD/FlushE high for exactly 1 (resp. 3) cycles, then low. Rd_E=0 → no stall.
- MUL/DIV, MD_LAT=4: MdStart_E with Rd_E=9 → MdBusy high 4 cycles, MdDone in the 4th, MdRd=9. Dependent RS1_D=9 stalls through the MdDone cycle and releases the next cycle. Independent RS1_D=3 never stalls.
- WAW and structural: MdBusy with Rd_D=9 pending → stall. MdOp_D while busy → stall until the MdDone cycle. MdStart_E while busy → ignored, MdRd unchanged.
- Branch during stall: load-use stall with LOAD_LAT=3 plus PCSrc_E in the 1st cycle → FlushD=FlushE=1, StallF=0. Next cycle, no stall.
- Async reset: assert rst=0 mid-MD (counter=2) without a clock edge → MdBusy=0 and all outputs 0 immediately. After release, x9 is no longer pending.
